mole_gen: RTL
=============

// Module: mole_gen
// PURPOSE
//  Game controller and mole-position source for the whack-a-mole matrix display. It produces
//  the state, rowran and colran signals that the matrix scan logic consumes. Clocked by
//  clk_half (one edge per mole interval). Each edge it scores the sampled hit level, advances
//  the round, and emits a new pseudo-random mole, or ends the game in WIN or LOSE.
// PARAMETERS
//  LFSR_SEED   16'hACE1  non-zero seed loaded into the 16-bit LFSR on reset
//  WIN_SCORE   10        hits needed to win (1..2**SCORE_W-1)
//  MAX_ROUNDS  20        moles presented before a loss is declared (1..2**RND_W-1)
//  SCORE_W     5         score counter width
//  RND_W       5         round counter width
// PORTS
//  clk_half  in   1        mole-interval clock; all logic on its rising edge
//  rst       in   1        synchronous reset, active-high
//  start     in   1        level; start a game from IDLE, or return to IDLE from WIN/LOSE
//  hit       in   1        level; high = current mole hit, held by key logic until next edge
//  state     out  2        00 IDLE, 01 PLAY, 10 WIN, 11 LOSE
//  rowran    out  3        mole row, 2..5 in PLAY, 0 otherwise
//  colran    out  3        mole column code, 2..5 in PLAY (2 = leftmost), 0 otherwise
//  score     out  SCORE_W  hits this game
//  round     out  RND_W    index of the current mole, 1..MAX_ROUNDS; 0 in IDLE
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=00, rowran=0, colran=0, score=0, round=0, lfsr=LFSR_SEED.
//    Reset overrides every other input, including mid-game.
//  - LFSR: 16-bit Galois, shift right, XOR mask 16'hB400 when the shifted-out bit=1.
//    Advances on every non-reset edge in every state, so idle time randomises the first mole.
//    lfsr_n is the next value.
//  - Mole from lfsr_n: row = {1'b0,lfsr_n[1:0]}+3'd2, col = {1'b0,lfsr_n[3:2]}+3'd2.
//    The mole is registered on the same edge; outputs change exactly 1 edge after the event.
//  - IDLE: start=1 -> PLAY, score=0, round=1, load mole. start=0 -> hold, outputs 0.
//  - PLAY, each edge:
//      s_n = score+hit (saturating at all-ones).
//      1) s_n >= WIN_SCORE -> WIN, score=s_n, rowran=colran=0.
//      2) else round==MAX_ROUNDS -> LOSE, score=s_n, rowran=colran=0.
//      3) else score=s_n, round+1, load new mole.
//    If the final round is hit and that hit reaches WIN_SCORE, WIN has priority over LOSE.
//    start is ignored in PLAY.
//  - WIN/LOSE: outputs frozen; score/round keep their final values; hit is ignored.
//    start=1 -> IDLE with score=0, round=0.
//  - hit is only sampled in PLAY. One edge scores at most 1 point, even if hit stays high for
//    several intervals.
//  - Unused state codes cannot occur. Any illegal value recovers to IDLE on the next edge.
// CONFIGURATION
//  NO_REPEAT_EN defined: if the new {row,col} equals the current {rowran,colran} while in
//    PLAY, col is replaced by ((col-2+1) mod 4)+2. Row is unchanged. Consecutive moles never
//    share a position. The first mole after IDLE is not checked.
//  NO_REPEAT_EN undefined: the LFSR-derived position is used as-is. Repeats are allowed.
// TESTING
//  1 rst=1 for 2 edges -> state=00, rowran=0, colran=0, score=0, round=0. Release with
//    start=0 for 5 edges -> outputs unchanged.
//  2 From reset, 1 idle edge, start=1 -> state=01, round=1. rowran/colran equal the values
//    computed by a golden LFSR model from 16'hACE1 (2 shifts), both within 2..5.
//  3 hit=1 on 10 consecutive PLAY edges -> score increments 1..10. state=10 on the 10th
//    edge, rowran=colran=0. Extra start=1 -> state=00, score=0.
//  4 hit=0 for all rounds -> round reaches 20, next edge state=11, score=0. Variant: hits on
//    rounds 12..20 (9 hits) plus round 11 -> WIN on the round-20 edge, not LOSE.
//  5 rst=1 asserted at round 7 with score=4 -> next edge all outputs at reset values.
//    hit=1 in IDLE/WIN/LOSE leaves score unchanged.
//  6 NO_REPEAT_EN: 500 PLAY rounds with hit=0 and MAX_ROUNDS overridden to 31 (restart as
//    needed) -> no two consecutive equal {rowran,colran}; compare against the golden model
//    with the column-rotate rule.

Source files
------------

// File: rtl/mole_gen.sv
// Whack-a-mole game controller: scores hits, counts rounds and emits LFSR-driven mole positions.
// Optional macro NO_REPEAT_EN rotates the column so consecutive moles never share a position.
module mole_gen #(
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          WIN_SCORE  = 10,
  parameter int          MAX_ROUNDS = 20,
  parameter int          SCORE_W    = 5,
  parameter int          RND_W      = 5
) (
  input  logic               clk_half,
  input  logic               rst,
  input  logic               start,
  input  logic               hit,
  output logic [1:0]         state,
  output logic [2:0]         rowran,
  output logic [2:0]         colran,
  output logic [SCORE_W-1:0] score,
  output logic [RND_W-1:0]   round
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    WIN  = 2'b10,
    LOSE = 2'b11
  } state_t;

  localparam logic [SCORE_W-1:0] WIN_S   = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] ONE_S   = SCORE_W'(1);
  localparam logic [RND_W-1:0]   RND_MAX = RND_W'(MAX_ROUNDS);
  localparam logic [RND_W-1:0]   ONE_R   = RND_W'(1);

  state_t             st;
  logic [15:0]        lfsr;
  logic [15:0]        lfsr_n;
  logic [2:0]         row_n;
  logic [2:0]         col_n;
  logic [SCORE_W-1:0] s_n;
  logic               win_hit;

  assign state = st;

  always_comb begin
    lfsr_n = {1'b0, lfsr[15:1]};
    if (lfsr[0]) lfsr_n = lfsr_n ^ 16'hB400;
  end

  // Mole position from the next LFSR value; the column rotation only exists in the no-repeat build
  always_comb begin
    row_n = {1'b0, lfsr_n[1:0]} + 3'd2;
    col_n = {1'b0, lfsr_n[3:2]} + 3'd2;
`ifdef NO_REPEAT_EN
    if (st == PLAY && row_n == rowran && col_n == colran)
      col_n = {1'b0, lfsr_n[3:2] + 2'd1} + 3'd2;
`endif
  end

  always_comb begin
    s_n = score;
    if (hit && !(&score)) s_n = score + ONE_S;
    win_hit = (s_n >= WIN_S);
  end

  // Win is tested before the round limit so a winning hit on the last mole is a WIN
  always_ff @(posedge clk_half) begin
    if (rst) begin
      st     <= IDLE;
      rowran <= '0;
      colran <= '0;
      score  <= '0;
      round  <= '0;
      lfsr   <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_n;
      case (st)
        IDLE: begin
          rowran <= '0;
          colran <= '0;
          score  <= '0;
          round  <= '0;
          if (start) begin
            st     <= PLAY;
            round  <= ONE_R;
            rowran <= row_n;
            colran <= col_n;
          end
        end
        PLAY: begin
          score <= s_n;
          if (win_hit) begin
            st     <= WIN;
            rowran <= '0;
            colran <= '0;
          end else if (round == RND_MAX) begin
            st     <= LOSE;
            rowran <= '0;
            colran <= '0;
          end else begin
            round  <= round + ONE_R;
            rowran <= row_n;
            colran <= col_n;
          end
        end
        WIN, LOSE: begin
          if (start) begin
            st    <= IDLE;
            score <= '0;
            round <= '0;
          end
        end
        default: begin
          st     <= IDLE;
          rowran <= '0;
          colran <= '0;
          score  <= '0;
          round  <= '0;
        end
      endcase
    end
  end

endmodule
